// File: rtl/minterm_extractor.sv
// Sweeps a combinational function through every input vector and rebuilds its minterm mask.
// Optional MINTERM_STREAM_EN adds a per-minterm stream (mt_valid/mt_index).
module minterm_extractor #(
    parameter int unsigned N_IN   = 3,
    parameter int unsigned SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected,
    input  logic                 dut_out,
    output logic [N_IN-1:0]      dut_in,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   minterms,
    output logic                 match,
`ifdef MINTERM_STREAM_EN
    output logic                 mt_valid,
    output logic [N_IN-1:0]      mt_index,
`endif
    output logic [N_IN:0]        count
);

    localparam int unsigned IdxW = N_IN;
    localparam int unsigned CntW = N_IN + 1;
    localparam logic [IdxW-1:0] LastIdx   = IdxW'(2**N_IN - 1);
    localparam logic [3:0]      SettleCnt = 4'(SETTLE);

    typedef enum logic [1:0] {StIdle, StHold, StDone} state_e;

    state_e              state_q;
    logic [IdxW-1:0]     idx_q;
    logic [3:0]          cnt_q;
    logic [2**N_IN-1:0]  sampled_mask;

    // Mask including the bit being sampled this edge, so match sees the final vector.
    always_comb begin
        sampled_mask        = minterms;
        sampled_mask[idx_q] = dut_out;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            dut_in   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            minterms <= '0;
            match    <= 1'b0;
            count    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
`ifdef MINTERM_STREAM_EN
            mt_valid <= 1'b0;
            mt_index <= '0;
`endif
        end else begin
`ifdef MINTERM_STREAM_EN
            mt_valid <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        dut_in   <= '0;
                        idx_q    <= '0;
                        cnt_q    <= SettleCnt;
                        minterms <= '0;
                        count    <= '0;
                        match    <= 1'b0;
                        busy     <= 1'b1;
                        state_q  <= StHold;
                    end
                end
                StHold: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        minterms <= sampled_mask;
                        count    <= count + CntW'(dut_out);
`ifdef MINTERM_STREAM_EN
                        if (dut_out) begin
                            mt_valid <= 1'b1;
                            mt_index <= idx_q;
                        end
`endif
                        if (idx_q == LastIdx) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            dut_in  <= '0;
                            match   <= (sampled_mask == expected);
                        end else begin
                            idx_q  <= idx_q + IdxW'(1);
                            dut_in <= idx_q + IdxW'(1);
                            cnt_q  <= SettleCnt;
                        end
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_minterm_extractor.sv
// Bench for minterm_extractor: SETTLE=1 (dut A) and SETTLE=0 (dut B) instances
// driven by random truth tables and checked against a cycle-count reference model.
module tb_minterm_extractor;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] expected;
    logic [7:0] fmask;

    logic [2:0] in_a, in_b;
    logic       out_a, out_b;
    logic       busy_a, busy_b, done_a, done_b, match_a, match_b;
    logic [7:0] mt_a, mt_b;
    logic [3:0] cnt_a, cnt_b;
`ifdef MINTERM_STREAM_EN
    logic       mv_a, mv_b;
    logic [2:0] mi_a, mi_b;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // The function under test is an arbitrary truth table.
    assign out_a = fmask[in_a];
    assign out_b = fmask[in_b];

    always #5 clk = ~clk;

    minterm_extractor #(.N_IN(3), .SETTLE(1)) u_dut_a (
        .clk(clk), .reset(reset), .start(start), .expected(expected), .dut_out(out_a),
        .dut_in(in_a), .busy(busy_a), .done(done_a), .minterms(mt_a), .match(match_a),
`ifdef MINTERM_STREAM_EN
        .mt_valid(mv_a), .mt_index(mi_a),
`endif
        .count(cnt_a)
    );

    minterm_extractor #(.N_IN(3), .SETTLE(0)) u_dut_b (
        .clk(clk), .reset(reset), .start(start), .expected(expected), .dut_out(out_b),
        .dut_in(in_b), .busy(busy_b), .done(done_b), .minterms(mt_b), .match(match_b),
`ifdef MINTERM_STREAM_EN
        .mt_valid(mv_b), .mt_index(mi_b),
`endif
        .count(cnt_b)
    );

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; expected = 8'h00; fmask = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_a, busy_a, done_a, mt_a, match_a, cnt_a} !== 17'd0) begin
            n_err++;
            $display("FAIL reset_a: got in=%0d busy=%0b done=%0b mt=%h match=%0b cnt=%0d want all 0",
                     in_a, busy_a, done_a, mt_a, match_a, cnt_a);
        end
        n_cmp++;
        if ({in_b, busy_b, done_b, mt_b, match_b, cnt_b} !== 17'd0) begin
            n_err++;
            $display("FAIL reset_b: got in=%0d busy=%0b done=%0b mt=%h match=%0b cnt=%0d want all 0",
                     in_b, busy_b, done_b, mt_b, match_b, cnt_b);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One sweep; k counts edges after the start edge E0.
    task automatic run_sweep(input logic [7:0] fm, input logic [7:0] ex, input bit hold_start,
                             input string name);
        logic [2:0] e_in;
        logic       e_match;
        logic [3:0] e_cnt;
        fmask    = fm;
        expected = ex;
        e_match  = (fm == ex);
        e_cnt    = 4'($countones(fm));
        start    = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            e_in = (k < 16) ? 3'(k / 2) : 3'd0;
            n_cmp++;
            if (in_a !== e_in || busy_a !== (k < 16) || done_a !== (k == 16)) begin
                n_err++;
                $display("FAIL %s_a_seq k=%0d: got in=%0d busy=%0b done=%0b want in=%0d busy=%0b done=%0b",
                         name, k, in_a, busy_a, done_a, e_in, (k < 16), (k == 16));
            end
            if (k == 16 || k == 20) begin
                n_cmp++;
                if (mt_a !== fm || cnt_a !== e_cnt || match_a !== e_match) begin
                    n_err++;
                    $display("FAIL %s_a_result k=%0d: got mt=%h cnt=%0d match=%0b want mt=%h cnt=%0d match=%0b",
                             name, k, mt_a, cnt_a, match_a, fm, e_cnt, e_match);
                end
            end
`ifdef MINTERM_STREAM_EN
            begin
                logic ev;
                ev = (k >= 2 && k <= 16 && (k % 2) == 0) ? fm[k/2-1] : 1'b0;
                n_cmp++;
                if (mv_a !== ev || (ev && mi_a !== 3'(k/2-1))) begin
                    n_err++;
                    $display("FAIL %s_a_stream k=%0d: got v=%0b idx=%0d want v=%0b idx=%0d",
                             name, k, mv_a, mi_a, ev, k/2-1);
                end
            end
`endif
            if (!hold_start) begin
                e_in = (k < 8) ? 3'(k) : 3'd0;
                n_cmp++;
                if (in_b !== e_in || busy_b !== (k < 8) || done_b !== (k == 8)) begin
                    n_err++;
                    $display("FAIL %s_b_seq k=%0d: got in=%0d busy=%0b done=%0b want in=%0d busy=%0b done=%0b",
                             name, k, in_b, busy_b, done_b, e_in, (k < 8), (k == 8));
                end
                if (k == 8) begin
                    n_cmp++;
                    if (mt_b !== fm || cnt_b !== e_cnt || match_b !== e_match) begin
                        n_err++;
                        $display("FAIL %s_b_result: got mt=%h cnt=%0d match=%0b want mt=%h cnt=%0d match=%0b",
                                 name, mt_b, cnt_b, match_b, fm, e_cnt, e_match);
                    end
                end
`ifdef MINTERM_STREAM_EN
                begin
                    logic evb;
                    evb = (k <= 8) ? fm[k-1] : 1'b0;
                    n_cmp++;
                    if (mv_b !== evb || (evb && mi_b !== 3'(k-1))) begin
                        n_err++;
                        $display("FAIL %s_b_stream k=%0d: got v=%0b idx=%0d want v=%0b idx=%0d",
                                 name, k, mv_b, mi_b, evb, k-1);
                    end
                end
`endif
            end
            if (hold_start && k == 17) start = 1'b0;
        end
    endtask

    task automatic test_directed();
        run_sweep(8'h70, 8'h70, 1'b0, "abc_match");
        run_sweep(8'h70, 8'h71, 1'b0, "abc_nomatch");
        run_sweep(8'hFF, 8'hFF, 1'b0, "tied1");
        run_sweep(8'h00, 8'h00, 1'b0, "tied0");
    endtask

    task automatic test_random();
        logic [7:0] fm, ex;
        for (int i = 0; i < 6; i++) begin
            fm = 8'($urandom);
            ex = (i % 2 == 0) ? fm : (fm ^ (8'd1 << $urandom_range(7, 0)));
            run_sweep(fm, ex, 1'b0, "random");
        end
    endtask

    task automatic test_back_to_back();
        run_sweep(8'h5A, 8'h5A, 1'b1, "held_start");
        // dut B restarted on the held start; realign both instances.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_sweep();
        bit saw_done;
        fmask = 8'hA7; expected = 8'hA7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_cmp++;
        if (in_a !== 3'd3) begin
            n_err++;
            $display("FAIL mid_pre_in: got %0d want 3", in_a);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_cmp++;
        if (busy_a !== 1'b0 || in_a !== 3'd0 || mt_a !== 8'h00 || cnt_a !== 4'd0 || done_a !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: got busy=%0b in=%0d mt=%h cnt=%0d done=%0b want 0",
                     busy_a, in_a, mt_a, cnt_a, done_a);
        end
        saw_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done_a || done_b || busy_a) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done) begin
            n_err++;
            $display("FAIL mid_no_done: got activity after reset want idle");
        end
        run_sweep(8'h3C, 8'h3C, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
